// File: rtl/arith_arbiter.sv
// rtl/arith_arbiter.sv - two-requester round-robin arbiter in front of a shared arithmetic unit
// One operation is in flight at a time; divide-by-zero is answered locally without using the unit.
module arith_arbiter #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0_VALID,
    input  logic [IN_WIDTH-1:0]  REQ0_A,
    input  logic [IN_WIDTH-1:0]  REQ0_B,
    input  logic [1:0]           REQ0_FUN,
    output logic                 REQ0_READY,
    input  logic                 REQ1_VALID,
    input  logic [IN_WIDTH-1:0]  REQ1_A,
    input  logic [IN_WIDTH-1:0]  REQ1_B,
    input  logic [1:0]           REQ1_FUN,
    output logic                 REQ1_READY,
    output logic                 RSP_VALID,
    output logic                 RSP_ID,
    output logic [OUT_WIDTH-1:0] RSP_DATA,
    output logic                 RSP_ERR,
    input  logic                 RSP_READY,
    output logic [IN_WIDTH-1:0]  AU_A,
    output logic [IN_WIDTH-1:0]  AU_B,
    output logic [1:0]           AU_FUN,
    output logic                 AU_EN,
    input  logic [OUT_WIDTH-1:0] AU_OUT,
    input  logic                 AU_FLAG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 last_gnt_q;
    logic [IN_WIDTH-1:0]  a_q, b_q;
    logic [1:0]           fun_q;
    logic                 id_q;
    logic [OUT_WIDTH-1:0] rsp_data_q;
    logic                 rsp_err_q;

    logic                 gnt_id;
    logic                 accept;
    logic                 div_zero;
    logic [IN_WIDTH-1:0]  sel_a, sel_b;
    logic [1:0]           sel_fun;

    // Contention goes to the requester that was not served last.
    always_comb begin
        if (REQ0_VALID && REQ1_VALID) begin
            gnt_id = ~last_gnt_q;
        end else begin
            gnt_id = REQ1_VALID;
        end
    end

    assign sel_a    = gnt_id ? REQ1_A   : REQ0_A;
    assign sel_b    = gnt_id ? REQ1_B   : REQ0_B;
    assign sel_fun  = gnt_id ? REQ1_FUN : REQ0_FUN;
    assign div_zero = (sel_fun == 2'b11) && (sel_b == '0);
    assign accept   = REQ0_READY || REQ1_READY;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = div_zero ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (RSP_READY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            last_gnt_q <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q        <= sel_a;
                b_q        <= sel_b;
                fun_q      <= sel_fun;
                id_q       <= gnt_id;
                last_gnt_q <= gnt_id;
                if (div_zero) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end
            if (state_q == S_WAIT) begin
                rsp_data_q <= AU_OUT;
                rsp_err_q  <= !AU_FLAG;
            end
        end
    end

    // Every output is forced low while reset is held, independent of the state register.
    always_comb begin
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RSP_VALID  = 1'b0;
        RSP_ID     = 1'b0;
        RSP_DATA   = '0;
        RSP_ERR    = 1'b0;
        AU_EN      = 1'b0;
        AU_A       = '0;
        AU_B       = '0;
        AU_FUN     = '0;
        if (RST) begin
            RSP_ID   = id_q;
            RSP_DATA = rsp_data_q;
            RSP_ERR  = rsp_err_q;
            case (state_q)
                S_IDLE: begin
                    REQ0_READY = REQ0_VALID && !gnt_id;
                    REQ1_READY = REQ1_VALID && gnt_id;
                end
                S_ISSUE: begin
                    AU_EN  = 1'b1;
                    AU_A   = a_q;
                    AU_B   = b_q;
                    AU_FUN = fun_q;
                end
                S_RESP:  RSP_VALID = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_arbiter.sv
// tb/tb_arith_arbiter.sv - scoreboard bench for arith_arbiter with a behavioural unit and grant model
// Issue-side model pushes expected responses; a separate monitor pops and compares.
module tb_arith_arbiter;
    localparam int IW = 16;
    localparam int OW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
    logic [IW-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic [1:0]    REQ0_FUN, REQ1_FUN;
    logic          RSP_VALID, RSP_ID, RSP_ERR, RSP_READY;
    logic [OW-1:0] RSP_DATA;
    logic [IW-1:0] AU_A, AU_B;
    logic [1:0]    AU_FUN;
    logic          AU_EN;
    logic [OW-1:0] AU_OUT = '0;
    logic          AU_FLAG = 1'b0;

    arith_arbiter #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN), .REQ1_READY(REQ1_READY),
        .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .RSP_READY(RSP_READY),
        .AU_A(AU_A), .AU_B(AU_B), .AU_FUN(AU_FUN), .AU_EN(AU_EN), .AU_OUT(AU_OUT), .AU_FLAG(AU_FLAG)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [IW-1:0] a; logic [IW-1:0] b; logic [1:0] fun; } op_t;
    typedef struct { logic id; logic [OW-1:0] data; logic err; int due; } rsp_t;

    op_t  ops0[$], ops1[$];
    rsp_t exp_q[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   rr_mode = 0, gap_pct = 0, drop_pct = 0;
    logic force_flag = 1'b0;
    logic acc0 = 1'b0, acc1 = 1'b0;
    logic busy_m = 1'b0, last_m = 1'b1, div0_m = 1'b0;
    int   acc_cyc = 0;
    op_t  cur;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [OW-1:0] calc(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [1:0] f);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: r = (sb == 0) ? 0 : sa / sb;
        endcase
        return OW'(r);
    endfunction

    function automatic op_t mk(input int a, input int b, input logic [1:0] f);
        op_t o;
        o.a = IW'(a);
        o.b = IW'(b);
        o.fun = f;
        return o;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Shared arithmetic unit: registered result one cycle after enable.
    always @(posedge CLK) begin
        if (AU_EN) begin
            AU_OUT  <= calc(AU_A, AU_B, AU_FUN);
            AU_FLAG <= !force_flag;
        end
    end

    // Issue side: grant/ready model, unit-enable timing, expected response push.
    always @(negedge CLK) begin : issue_model
        logic g, e0, e1;
        rsp_t r;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!RST) begin
            busy_m = 1'b0;
            last_m = 1'b1;
            exp_q.delete();
        end else begin
            g  = (REQ0_VALID && REQ1_VALID) ? !last_m : REQ1_VALID;
            e0 = !busy_m && REQ0_VALID && !g;
            e1 = !busy_m && REQ1_VALID && g;
            chk("ready0", REQ0_READY, e0);
            chk("ready1", REQ1_READY, e1);
            chk("au_en", AU_EN, busy_m && !div0_m && (cyc == acc_cyc + 1));
            chk("au_ops", {AU_A, AU_B, AU_FUN}, AU_EN ? {cur.a, cur.b, cur.fun} : 34'd0);
            if (busy_m && RSP_VALID && RSP_READY) busy_m = 1'b0;
            if (e0 || e1) begin
                cur.a   = g ? REQ1_A : REQ0_A;
                cur.b   = g ? REQ1_B : REQ0_B;
                cur.fun = g ? REQ1_FUN : REQ0_FUN;
                div0_m  = (cur.fun == 2'b11) && (cur.b == '0);
                r.id    = g;
                r.data  = div0_m ? '0 : calc(cur.a, cur.b, cur.fun);
                r.err   = div0_m || force_flag;
                r.due   = cyc + (div0_m ? 1 : 3);
                exp_q.push_back(r);
                busy_m  = 1'b1;
                last_m  = g;
                acc_cyc = cyc;
                acc0    = !g;
                acc1    = g;
            end
        end
    end

    // Response monitor: reset quietness, response timing and contents.
    always @(negedge CLK) begin : rsp_monitor
        logic exp_v;
        if (!RST) begin
            chk("rst_ctrl", {REQ0_READY, REQ1_READY, RSP_VALID, RSP_ID, RSP_ERR, AU_EN, AU_FUN}, 0);
            chk("rst_data", RSP_DATA, 0);
            chk("rst_au_ab", {AU_A, AU_B}, 0);
        end else begin
            exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
            chk("rsp_valid", RSP_VALID, exp_v);
            if (RSP_VALID && exp_v) begin
                chk("rsp_id", RSP_ID, exp_q[0].id);
                chk("rsp_data", RSP_DATA, exp_q[0].data);
                chk("rsp_err", RSP_ERR, exp_q[0].err);
                if (RSP_READY) void'(exp_q.pop_front());
            end
        end
    end

    // Requester and consumer drivers.
    initial begin : drivers
        op_t o;
        REQ0_VALID = 0; REQ0_A = '0; REQ0_B = '0; REQ0_FUN = '0;
        REQ1_VALID = 0; REQ1_A = '0; REQ1_B = '0; REQ1_FUN = '0;
        RSP_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (acc0 || (REQ0_VALID && $urandom_range(99) < drop_pct)) REQ0_VALID = 1'b0;
            if (!REQ0_VALID && ops0.size() > 0 && $urandom_range(99) >= gap_pct) begin
                o = ops0.pop_front();
                REQ0_A = o.a; REQ0_B = o.b; REQ0_FUN = o.fun; REQ0_VALID = 1'b1;
            end
            if (acc1 || (REQ1_VALID && $urandom_range(99) < drop_pct)) REQ1_VALID = 1'b0;
            if (!REQ1_VALID && ops1.size() > 0 && $urandom_range(99) >= gap_pct) begin
                o = ops1.pop_front();
                REQ1_A = o.a; REQ1_B = o.b; REQ1_FUN = o.fun; REQ1_VALID = 1'b1;
            end
            RSP_READY = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((ops0.size() > 0 || ops1.size() > 0 || REQ0_VALID || REQ1_VALID || busy_m || exp_q.size() > 0)
               && n < budget) begin
            @(posedge CLK);
            n++;
        end
        chk("idle_within_budget", n < budget, 1);
        @(posedge CLK);
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK); #2;
        RST = 1'b0;
        repeat (n) @(posedge CLK);
        #2 RST = 1'b1;
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;

        ops0.push_back(mk(7, -3, 2'd0));
        wait_idle(100);

        do_reset(2);
        ops0.push_back(mk(100, -200, 2'd2));
        ops1.push_back(mk(5, 9, 2'd1));
        wait_idle(100);

        ops1.push_back(mk(50, 0, 2'd3));
        wait_idle(100);

        rr_mode = 2;
        ops0.push_back(mk(-1234, 77, 2'd1));
        n = 0;
        while (!RSP_VALID && n < 50) begin @(negedge CLK); n++; end
        chk("stall_rsp_seen", RSP_VALID, 1);
        repeat (5) @(negedge CLK);
        ops1.push_back(mk(3, 4, 2'd2));
        repeat (2) @(negedge CLK);
        rr_mode = 0;
        wait_idle(100);

        ops0.push_back(mk(1, 2, 2'd0));
        n = 0;
        while (!AU_EN && n < 50) begin @(negedge CLK); n++; end
        chk("abort_issue_seen", AU_EN, 1);
        @(posedge CLK); #2 RST = 1'b0;
        @(posedge CLK); #2 RST = 1'b1;
        repeat (4) @(posedge CLK);
        ops0.push_back(mk(11, 22, 2'd1));
        ops1.push_back(mk(-8, 3, 2'd3));
        wait_idle(100);

        force_flag = 1'b1;
        ops1.push_back(mk(9, 3, 2'd3));
        wait_idle(100);
        force_flag = 1'b0;

        rr_mode = 1; gap_pct = 30; drop_pct = 5;
        for (int i = 0; i < 150; i++) begin
            op_t o;
            o.a   = IW'($urandom);
            o.b   = ($urandom_range(7) == 0) ? '0 : IW'($urandom);
            o.fun = 2'($urandom);
            if ($urandom_range(1) == 1) ops0.push_back(o); else ops1.push_back(o);
        end
        wait_idle(20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
